// File: rtl/e_mdu_pkg.sv
// Shared CPU definitions for HI/LO multiply-divide ops (decoder, hazard unit, MDU).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a; the hazard unit stalls issue while the MDU reports busy.
package e_mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Default busy periods of the iterative units being modelled.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_mul_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// 64-bit combinational product / quotient-remainder of the captured operands.
// Latency: purely combinational; the owner decides when to commit the result.
// Backpressure: none; result and divide-by-zero flag follow the inputs.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               sdiv_ovf;

    // Sign-extend both factors so the low 64 bits are the exact signed product.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divisor is forced nonzero so the dividers never see x/0; the result is
    // discarded anyway when div_zero is set.
    assign b_safe   = (b == 32'd0) ? 32'd1 : b;
    assign quo_s    = $signed(a) / $signed(b_safe);
    assign rem_s    = $signed(a) % $signed(b_safe);
    assign quo_u    = a / b_safe;
    assign rem_u    = a % b_safe;
    assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the result for the captured op; most-negative / -1 wraps explicitly.
    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  res = hilo_t'(prod_s);
            MD_MULTU: res = hilo_t'(prod_u);
            MD_DIV: begin
                div_zero = (b == 32'd0);
                if (sdiv_ovf) begin
                    res.hi = 32'd0;
                    res.lo = 32'h8000_0000;
                end else begin
                    res.hi = rem_s;
                    res.lo = quo_s;
                end
            end
            MD_DIVU: begin
                div_zero = (b == 32'd0);
                res.hi   = rem_u;
                res.lo   = quo_u;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning architectural HI/LO.
// Latency: mult MULT_CYCLES, div DIV_CYCLES; mthi/mtlo write at the issue edge.
// Backpressure: busy high while in flight; start is ignored then (no queueing).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    md_op_e           op_in;
    md_op_e           op_q;
    logic [31:0]      a_q, b_q;
    logic             cap, wr_res, wr_hi, wr_lo;
    hilo_t            calc_res;
    logic             calc_dz;

    assign op_in = md_op_e'(md_op);
    assign busy  = (state == BUSY);

    e_mdu_calc u_calc (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .res      (calc_res),
        .div_zero (calc_dz)
    );

    // State and down-counter register; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: accept long ops in IDLE, count down in BUSY, commit on the last cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        wr_res  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul_op(op_in)) begin
                        cap     = 1'b1;
                        cnt_n   = CNT_W'(MULT_CYCLES);
                        state_n = BUSY;
                    end else if (is_div_op(op_in)) begin
                        cap     = 1'b1;
                        cnt_n   = CNT_W'(DIV_CYCLES);
                        state_n = BUSY;
                    end else if (op_in == MD_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (op_in == MD_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    wr_res  = !calc_dz;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture and HI/LO updates; divide-by-zero leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= MD_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (cap) begin
                op_q <= op_in;
                a_q  <= src_a;
                b_q  <= src_b;
            end
            if (wr_res) begin
                hi <= calc_res.hi;
                lo <= calc_res.lo;
            end
            if (wr_hi) hi <= src_a;
            if (wr_lo) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu.
// Latency: checks exact busy length and HI/LO commit timing per op.
// Backpressure: checks start is ignored while busy and accepted as busy falls.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    e_mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse, then scramble operands so late changes are visible.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0BAD_F00D;
    endtask

    // Count cycles with busy high, bounded.
    task automatic count_busy(output int nb);
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd5;
        src_a = 32'h5555_5555;
        src_b = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
        else n_pass++;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo);
        else n_pass++;
    endtask

    task automatic test_mult();
        int nb;
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        n_checks++;
        if (busy !== 1'b1 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL mult_first_cycle got busy=%0b hi=%h lo=%h want 1/0/0", busy, hi, lo);
        else n_pass++;
        count_busy(nb);
        n_checks++;
        if (nb != 5) $display("FAIL mult_busy_len got %0d want 5", nb);
        else n_pass++;
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
            $display("FAIL mult_result got %h_%h want ffffffff_fffffffe", hi, lo);
        else n_pass++;
    endtask

    task automatic test_multu();
        int nb;
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        count_busy(nb);
        n_checks++;
        if (nb != 5) $display("FAIL multu_busy_len got %0d want 5", nb);
        else n_pass++;
        n_checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE)
            $display("FAIL multu_result got %h_%h want 00000001_fffffffe", hi, lo);
        else n_pass++;
    endtask

    task automatic test_div();
        int nb;
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        count_busy(nb);
        n_checks++;
        if (nb != 10) $display("FAIL div_busy_len got %0d want 10", nb);
        else n_pass++;
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL div_neg7_by_2 got %h_%h want ffffffff_fffffffd", hi, lo);
        else n_pass++;
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(nb);
        n_checks++;
        if (nb != 10 || hi !== 32'h0 || lo !== 32'h8000_0000)
            $display("FAIL div_ovf got n=%0d %h_%h want 10 00000000_80000000", nb, hi, lo);
        else n_pass++;
        issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
        count_busy(nb);
        n_checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'h7FFF_FFFC)
            $display("FAIL divu_result got %h_%h want 00000001_7ffffffc", hi, lo);
        else n_pass++;
    endtask

    task automatic test_divu_zero();
        int nb;
        issue(3'd5, 32'h0000_0011, 32'h0);
        issue(3'd6, 32'h0000_0022, 32'h0);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL preload got busy=%0b %h_%h want 0 00000011_00000022", busy, hi, lo);
        else n_pass++;
        issue(3'd4, 32'h0000_0005, 32'h0);
        count_busy(nb);
        n_checks++;
        if (nb != 10) $display("FAIL divzero_busy_len got %0d want 10", nb);
        else n_pass++;
        n_checks++;
        if (hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL divzero_hilo got %h_%h want 00000011_00000022", hi, lo);
        else n_pass++;
    endtask

    task automatic test_ignored();
        issue(3'd7, 32'h7777_7777, 32'h3);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL op7_ignored got busy=%0b %h_%h want 0 00000011_00000022", busy, hi, lo);
        else n_pass++;
        issue(3'd0, 32'h7777_7777, 32'h3);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL op0_ignored got busy=%0b %h_%h want 0 00000011_00000022", busy, hi, lo);
        else n_pass++;
    endtask

    task automatic test_mt();
        int nb;
        issue(3'd6, 32'h0000_1234, 32'h0);
        n_checks++;
        if (lo !== 32'h1234 || hi !== 32'h11)
            $display("FAIL mtlo got %h_%h want 00000011_00001234", hi, lo);
        else n_pass++;
        issue(3'd1, 32'h0000_0003, 32'h0000_0004);
        issue(3'd5, 32'h0000_AAAA, 32'h0);
        n_checks++;
        if (busy !== 1'b1 || hi !== 32'h11)
            $display("FAIL mthi_in_busy got busy=%0b hi=%h want 1 00000011", busy, hi);
        else n_pass++;
        count_busy(nb);
        n_checks++;
        if (nb != 4 || hi !== 32'h0 || lo !== 32'h0000_000C)
            $display("FAIL mult_after_mthi got n=%0d %h_%h want 4 00000000_0000000c", nb, hi, lo);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nb;
        issue(3'd2, 32'h6, 32'h7);
        count_busy(nb);
        n_checks++;
        if (lo !== 32'd42 || hi !== 32'h0) $display("FAIL b2b_first got %h_%h want 0_2a", hi, lo);
        else n_pass++;
        issue(3'd2, 32'h8, 32'h9);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%0b want 1", busy);
        else n_pass++;
        count_busy(nb);
        n_checks++;
        if (nb != 5 || lo !== 32'd72 || hi !== 32'h0)
            $display("FAIL b2b_second got n=%0d %h_%h want 5 0_48", nb, hi, lo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue(3'd5, 32'h0000_0099, 32'h0);
        issue(3'd1, 32'h0000_0005, 32'h0000_0005);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_mid got busy=%0b %h_%h want 0 0_0", busy, hi, lo);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_mid_late got busy=%0b %h_%h want 0 0_0", busy, hi, lo);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        src_a    = 32'h0;
        src_b    = 32'h0;
        #2;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_ignored();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  md_op valid this cycle (E-stage issue).
REQ-006 SHALL have port md_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, ignored.
REQ-007 SHALL have port src_a  input  32  forwarded rs operand.
REQ-008 SHALL have port src_b  input  32  forwarded rt operand.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL be a two-state FSM: IDLE, BUSY; busy = 1 exactly in BUSY.
REQ-013 SHALL accept a mult/multu/div/divu in IDLE with start=1: capture src_a, src_b, md_op; load down-counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
REQ-014 SHALL, for an op accepted at cycle t, hold busy=1 during cycles t+1..t+N (N = latency) and busy=0 from cycle t+N+1.
REQ-015 SHALL write HI/LO at the edge ending cycle t+N, so the new values are visible from cycle t+N+1, coincident with busy falling.
REQ-016 SHALL compute from the captured operands only; src_a/src_b changes after cycle t have no effect.
REQ-017 SHALL produce mult/multu as a 64-bit signed/unsigned product: hi = [63:32], lo = [31:0].
REQ-018 SHALL produce div/divu with lo = quotient, truncated toward zero, and hi = remainder, sign of dividend for div.
REQ-019 SHALL, for signed 0x80000000 / 0xFFFFFFFF, give lo = 0x80000000 and hi = 0.
REQ-020 SHALL, on divide by zero, leave hi/lo unchanged while still running the full DIV_CYCLES busy period.
REQ-021 SHALL, for mthi/mtlo with start=1 in IDLE, write src_a into hi/lo at that edge; no busy period.
REQ-022 SHALL ignore start (any md_op) while in BUSY; the hazard unit stalls, and the block does not queue.
REQ-023 SHALL ignore start with md_op 0 or 7.
REQ-024 SHALL accept a new op in the same cycle busy falls (cycle t+N+1).
REQ-025 SHALL hold hi/lo at all times other than REQ-015/REQ-021 writes.

Reset
REQ-026 SHALL, with reset=1 at an edge, force IDLE, busy=0, hi=0, lo=0, and counter=0, overriding start.
REQ-027 SHALL, when reset is asserted mid-operation, discard the in-flight result, so it is never written to hi/lo.

Structure
REQ-028 SHALL take md_op encodings and default latency constants from a shared CPU package, which is also used by the decoder and hazard unit.
REQ-029 SHALL place the 64-bit combinational mult/div datapath in one sub-module, e_mdu_calc, with captured operands and op in and {hi,lo} result plus a div-by-zero flag out.
REQ-030 SHALL size the counter to hold max(MULT_CYCLES, DIV_CYCLES), 4 bits at defaults.

Verification
REQ-031 SHALL cover: mult 0xFFFFFFFF x 0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 SHALL cover: multu 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 SHALL cover: div 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: divu 5 / 0 with hi=0x11, lo=0x22 preloaded -> busy 10 cycles, hi=0x11, lo=0x22 afterwards.
REQ-035 SHALL cover: mtlo 0x1234 in IDLE -> lo=0x1234 next cycle, hi unchanged; mthi 0xAAAA during BUSY -> ignored, hi unchanged.
REQ-036 SHALL cover: mult started, reset pulsed in 3rd busy cycle -> next cycle busy=0, hi=lo=0, and no later result write.
